// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
// State encodings are plain localparams so legacy code can compare against raw codes.
package vga_fb_arbiter_pkg;

  typedef logic [1:0] fb_state_t;

  localparam fb_state_t S_IDLE  = 2'd0;
  localparam fb_state_t S_FETCH = 2'd1;
  localparam fb_state_t S_DONE  = 2'd2;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_pix_fifo.sv
// Prefetch FIFO between the framebuffer read port and the RGB datapath.
// Flush wins over push/pop; push and pop together are legal when full.
module vga_fb_arbiter_pix_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head,
  output logic              not_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              do_pop_s;
  logic              do_push_s;

  // Push/pop qualification; a full FIFO can still accept a push when it pops.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}}) && !flush;
    do_push_s = push && !flush && (!full_s || do_pop_s);
  end

  // Pointer, occupancy and storage update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Head is forced to zero when empty so downstream never sees stale pixels.
  always_comb begin
    count     = count_r;
    not_empty = (count_r != {CNT_W{1'b0}});
    if (not_empty) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer between raster-order scan-out prefetch and a pixel writer.
// Reads win each slot unless a starved writer has waited MAX_WAIT cycles and the FIFO is half full.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WAIT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              underrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TOTAL  = frame_pixels(H_ACTIVE, V_ACTIVE);

  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  FULL_CREDITS = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HALF_CREDITS = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT   = WAIT_W'(MAX_WAIT);

  fb_state_t         state_r;
  fb_state_t         state_next_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              inflight_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              underrun_r;

  logic [CNT_W-1:0]  fifo_count_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_valid_s;
  logic [CNT_W-1:0]  credits_s;
  logic              rd_want_s;
  logic              force_wr_s;
  logic              grant_rd_s;
  logic              grant_wr_s;
  logic              pop_s;

  vga_fb_arbiter_pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_pix_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (frame_start),
    .push      (inflight_r),
    .push_data (mem_rdata),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s),
    .not_empty (fifo_valid_s)
  );

  // Slot arbitration; the force condition ignores wr_valid so wr_ready never depends on it.
  always_comb begin
    credits_s  = fifo_count_s + CNT_W'(inflight_r);
    rd_want_s  = (state_r == S_FETCH) && (credits_s < FULL_CREDITS) && !frame_start;
    force_wr_s = (wait_cnt_r == WAIT_LIMIT) && (credits_s >= HALF_CREDITS);
    grant_rd_s = reset && rd_want_s && !force_wr_s;
    grant_wr_s = reset && !grant_rd_s;
    pop_s      = pix_req && fifo_valid_s && !frame_start;
  end

  // Memory port driven straight from the grant.
  always_comb begin
    wr_ready  = grant_wr_s;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (grant_rd_s) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr_r;
    end else if (grant_wr_s && wr_valid) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next-state: frame_start restarts fetch from any state.
  always_comb begin
    state_next_s = state_r;
    if (frame_start) begin
      state_next_s = S_FETCH;
    end else begin
      case (state_r)
        S_IDLE:  state_next_s = S_IDLE;
        S_FETCH: begin
          if (grant_rd_s && (rd_addr_r == LAST_ADDR)) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_DONE:  state_next_s = S_DONE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // FSM, read address and in-flight tracking; clearing inflight drops a read returning after frame_start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      rd_addr_r  <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
    end else if (frame_start) begin
      state_r    <= state_next_s;
      rd_addr_r  <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      inflight_r <= grant_rd_s;
      if (grant_rd_s) begin
        rd_addr_r <= rd_addr_r + ADDR_W'(1);
      end
    end
  end

  // Writer starvation counter, saturating at the force threshold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (!wr_valid || grant_wr_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (wait_cnt_r != WAIT_LIMIT) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end
  end

  // Sticky underrun flag; a request in the flush cycle is not an underrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      underrun_r <= 1'b0;
    end else if (pix_req && !fifo_valid_s && !frame_start) begin
      underrun_r <= 1'b1;
    end
  end

  assign pix_valid = fifo_valid_s;
  assign pix_data  = fifo_head_s;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter on a small 8x4 frame with a behavioural RAM.
module tb_vga_fb_arbiter;

  localparam int DW   = 8;
  localparam int AW   = 19;
  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int FD   = 8;
  localparam int MW   = 16;
  localparam int NPIX = HA * VA;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          pix_req;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          underrun;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 8'h00;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic wr_run   = 1'b0;

  logic [AW-1:0] exp_rd_q [$];
  logic [DW-1:0] exp_pix_q [$];
  wr_t           exp_wr_q [$];

  int rd_seen_frame = 0;
  int stall_run     = 0;
  int max_run       = 0;

  always #5 clock = ~clock;

  vga_fb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .FIFO_DEPTH(FD), .MAX_WAIT(MW)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .pix_req(pix_req),
    .pix_valid(pix_valid), .pix_data(pix_data), .underrun(underrun),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] pix_of(input int a);
    return DW'(a) ^ 8'h5A;
  endfunction

  // Framebuffer model: pixel region content is a fixed function of address, 1-cycle read latency.
  always @(posedge clock) begin
    if (mem_en && !mem_we) mem_rdata <= pix_of(int'(mem_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    exp_rd_q.delete();
    exp_pix_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_rd_q.push_back(AW'(i));
      exp_pix_q.push_back(pix_of(i));
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a memory access or delivers a pixel.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (frame_start) begin
        rd_seen_frame = 0;
        max_run       = 0;
      end
      if (mem_en && !mem_we) begin
        rd_seen_frame++;
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: read at addr %0d, none expected", mem_addr);
        end else begin
          check("rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        end
      end
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: write at addr %0d, none expected", mem_addr);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (wr_valid) begin
        check("wr_slot_used", 32'(mem_en), 32'd1);
        check("mem_we_vs_ready", 32'(mem_we), 32'(wr_ready));
        if (!wr_ready) stall_run++;
        else stall_run = 0;
        if (stall_run > max_run) max_run = stall_run;
      end else begin
        stall_run = 0;
      end
      if (pix_req && pix_valid && !frame_start) begin
        if (exp_pix_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pix_unexpected: popped %0h, none expected", pix_data);
        end else begin
          check("pix_data", 32'(pix_data), 32'(exp_pix_q.pop_front()));
        end
      end
    end
  end

  // Writer driver: holds each request until accepted, pushing its expectation when first presented.
  initial begin
    int   k;
    logic acc;
    wr_t  drop;
    k        = 0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    forever begin
      @(negedge clock);
      acc = wr_valid && wr_ready;
      @(posedge clock);
      #1;
      if (acc || !wr_valid) begin
        if (wr_run) begin
          wr_addr  = AW'(200 + (k % 50));
          wr_data  = DW'(k * 7 + 3);
          exp_wr_q.push_back('{addr: wr_addr, data: wr_data});
          wr_valid = 1'b1;
          k++;
        end else begin
          wr_valid = 1'b0;
        end
      end else if (!wr_run) begin
        wr_valid = 1'b0;
        drop = exp_wr_q.pop_back();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;

    // Reset: every output held low.
    step(3);
    @(negedge clock);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    step(1);
    reset = 1'b1;
    @(negedge clock);
    check("idle_wr_ready", 32'(wr_ready), 32'd1);
    check("idle_mem_en", 32'(mem_en), 32'd0);

    // Fill: eight back-to-back reads, then the FIFO is full and reads stop.
    step(1);
    new_frame();
    step(1);
    frame_start = 1'b0;
    step(12);
    @(negedge clock);
    check("fill_reads", 32'(rd_seen_frame), 32'd8);
    check("fill_mem_en", 32'(mem_en), 32'd0);
    check("fill_pix_valid", 32'(pix_valid), 32'd1);
    check("fill_pix_data", 32'(pix_data), 32'h5A);

    // Writer shares slots with pixel pops every other cycle.
    wr_run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix_req = (i % 2 == 0);
      step(1);
    end
    pix_req = 1'b0;
    @(negedge clock);
    check("half_rate_underrun", 32'(underrun), 32'd0);

    // Full-rate scan-out starves the writer until the forced grant.
    step(1);
    new_frame();
    pix_req = 1'b1;
    step(1);
    frame_start = 1'b0;
    pix_req     = 1'b0;
    @(negedge clock);
    check("flush_pix_valid", 32'(pix_valid), 32'd0);
    check("fs_req_underrun", 32'(underrun), 32'd0);
    step(9);
    pix_req = 1'b1;
    step(NPIX);
    pix_req = 1'b0;
    @(negedge clock);
    check("full_rate_underrun", 32'(underrun), 32'd0);
    check("max_stall", 32'(max_run), 32'd16);
    check("full_rate_reads", 32'(rd_seen_frame), 32'(NPIX));
    check("full_rate_pix_left", 32'(exp_pix_q.size()), 32'd0);
    wr_run = 1'b0;
    step(3);
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);

    // Underrun: request right after frame_start, persists across another frame_start.
    new_frame();
    step(1);
    frame_start = 1'b0;
    pix_req     = 1'b1;
    step(1);
    pix_req = 1'b0;
    @(negedge clock);
    check("underrun_set", 32'(underrun), 32'd1);
    step(1);
    new_frame();
    step(1);
    frame_start = 1'b0;
    @(negedge clock);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // frame_start with five pixels buffered and a read in flight.
    step(6);
    new_frame();
    @(negedge clock);
    check("fs5_pix_valid", 32'(pix_valid), 32'd1);
    check("fs5_pix_data", 32'(pix_data), 32'h5A);
    check("fs5_no_read", 32'(mem_en), 32'd0);
    step(1);
    frame_start = 1'b0;
    @(negedge clock);
    check("fs5_flushed", 32'(pix_valid), 32'd0);
    check("fs5_restart_en", 32'(mem_en), 32'd1);
    check("fs5_restart_addr", 32'(mem_addr), 32'd0);
    step(1);
    @(negedge clock);
    check("fs5_stale_dropped", 32'(pix_valid), 32'd0);
    step(1);
    @(negedge clock);
    check("fs5_first_valid", 32'(pix_valid), 32'd1);
    check("fs5_first_data", 32'(pix_data), 32'h5A);

    // Complete the frame, then the writer owns every slot in S_DONE.
    step(8);
    pix_req = 1'b1;
    step(NPIX);
    pix_req = 1'b0;
    @(negedge clock);
    check("frame_reads", 32'(rd_seen_frame), 32'(NPIX));
    check("frame_rd_left", 32'(exp_rd_q.size()), 32'd0);
    check("frame_pix_left", 32'(exp_pix_q.size()), 32'd0);
    check("frame_drained", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      @(negedge clock);
      check("done_wr_ready", 32'(wr_ready), 32'd1);
      check("done_mem_en", 32'(mem_en), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
